run_ctrl: RTL and testbench
===========================

Name: run_ctrl

Overview:
- Responder side of the top-level req/done start handshake.
- Accepts a start request and clears the PC. Enables execution until the decoder flags a halt, waits for the pipeline to drain, then raises done.
- Sits inside top_level between the external req/done pins and the PC/fetch/register-file write enables.
- Also reports the number of execution cycles in the run.

Parameters:
PIPE_DEPTH, 1, drain cycles between halt detection and done; legal range 0 to 15.
CNT_W, 16, width of the run-cycle counter.
WDOG_LIMIT, 4096, RUN-cycle limit before forced abort; used only when the optional feature is compiled in.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  start request; the start is taken on the falling edge of req.
- halt_i  input  1  decoded halt from the instruction currently in execute; qualified by state.
- pc_rst  output  1  one-cycle PC clear to the fetch unit.
- run_en  output  1  PC advance and register-file/memory write enable.
- busy  output  1  high in INIT, RUN and DRAIN.
- done  output  1  run complete; level, held until the next start.
- cycle_cnt  output  CNT_W  RUN cycles in the current or last run.
- timeout  output  1  last run ended by the watchdog.

Behaviour:
- Reset values: state IDLE; pc_rst=0, run_en=0, busy=0, done=0, cycle_cnt=0, timeout=0, drain counter 0.
- req_q register:
  - Samples req on every clock edge, including while reset is high; reset does not clear it.
  - This is required because top_level ties reset and req together.
- Start condition: req_q=1 and req=0, evaluated only when reset=0.
- Reset has priority over every transition. Reset mid-run returns to IDLE; no restart happens unless a later start condition occurs.
- States and outputs:
  - IDLE: all outputs 0.
    - Start condition -> INIT.
    - halt_i is ignored.
  - INIT: exactly one cycle.
    - pc_rst=1, busy=1, done=0, timeout=0.
    - cycle_cnt cleared to 0.
    - Unconditionally -> RUN.
  - RUN: run_en=1, busy=1.
    - cycle_cnt increments every RUN cycle, including the cycle halt_i is seen; it saturates at all-ones and never wraps.
    - halt_i=1 with PIPE_DEPTH>0 -> DRAIN, drain counter loaded with PIPE_DEPTH.
    - halt_i=1 with PIPE_DEPTH=0 -> DONE.
  - DRAIN: run_en=0, busy=1.
    - Counter decrements each cycle; reaching 1 -> DONE, so DRAIN lasts exactly PIPE_DEPTH cycles.
    - halt_i is ignored.
  - DONE: done=1, busy=0, run_en=0.
    - cycle_cnt and timeout hold.
    - Start condition -> INIT; done falls in the INIT cycle.
- req activity during INIT, RUN or DRAIN is ignored and not queued. req_q still tracks req.
- Latency:
  - Start edge sampled at edge E0 -> pc_rst high during the cycle after E0.
  - run_en first high after E1.
  - Halt sampled at edge H -> done high after edge H+PIPE_DEPTH.
- All outputs are registered state decodes; there is no combinational path from any input to any output.

Optional Feature:
RUN_CTRL_WATCHDOG_EN
- Defined:
  - In RUN, when cycle_cnt equals WDOG_LIMIT and halt_i=0, the next state is DONE with timeout=1.
  - DRAIN is skipped.
  - If halt_i=1 on that same cycle, the halt wins and timeout stays 0.
- Not defined:
  - timeout is constant 0 and RUN continues until halt or reset.
  - No watchdog logic is synthesized; WDOG_LIMIT is unused.

Test Plan:
1. PIPE_DEPTH=1; hold reset and req high for 1 cycle, then drop both; assert halt_i on the 3rd RUN cycle -> pc_rst for 1 cycle, run_en for 3 cycles, then 1 DRAIN cycle, then done=1 and stays high with cycle_cnt=3 and timeout=0.
2. From DONE after scenario 1, pulse req for 2 cycles with reset low -> done falls in the INIT cycle, cycle_cnt reads 0 in RUN, and a halt on RUN cycle 5 gives cycle_cnt=5 and done=1.
3. Assert reset alone for 2 cycles during RUN, with req low throughout -> IDLE, all outputs 0, and the block stays IDLE for 10 further cycles.
4. Hold halt_i=1 in IDLE and INIT; toggle req during RUN -> no early DONE, no restart, and pc_rst pulses only once.
5. PIPE_DEPTH=0; halt on RUN cycle 1 -> done=1 on the next edge and cycle_cnt=1.
6. WDOG_LIMIT=8, halt_i held 0:
   - With RUN_CTRL_WATCHDOG_EN defined -> done=1, timeout=1, cycle_cnt=8.
   - Without it -> still RUN after 20 cycles, with timeout=0 and cycle_cnt=20.

Source files
------------

// File: rtl/run_ctrl.sv
// ---------------------------------------------------------------------------
// run_ctrl
//   Responder side of the req/done start handshake. A falling edge on req
//   starts a run: one INIT cycle clears the PC, RUN enables execution until
//   the decoder reports a halt, DRAIN lets the pipeline empty for PIPE_DEPTH
//   cycles, and DONE holds done high until the next start. The number of
//   RUN cycles is reported on cycle_cnt.
//
//   Optional feature macro: RUN_CTRL_WATCHDOG_EN
//     When defined, a run that reaches WDOG_LIMIT RUN cycles without a halt
//     is forced into DONE with timeout=1. When undefined, timeout is tied 0
//     and no watchdog logic exists.
//
// Parameters
//   PIPE_DEPTH  drain cycles between halt and done (0..15)
//   CNT_W       width of the run-cycle counter
//   WDOG_LIMIT  RUN-cycle limit before a forced abort (watchdog build only)
//
// Ports
//   clk        in   system clock, all state updates on posedge
//   reset      in   synchronous, active-high reset
//   req        in   start request, start taken on its falling edge
//   halt_i     in   decoded halt of the instruction in execute
//   pc_rst     out  one-cycle PC clear to the fetch unit
//   run_en     out  PC advance and register-file/memory write enable
//   busy       out  high in INIT, RUN and DRAIN
//   done       out  run complete, held until the next start
//   cycle_cnt  out  RUN cycles in the current or last run (saturating)
//   timeout    out  last run was ended by the watchdog
// ---------------------------------------------------------------------------
module run_ctrl #(
    parameter int PIPE_DEPTH = 1,
    parameter int CNT_W      = 16,
    parameter int WDOG_LIMIT = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             halt_i,
    output logic             pc_rst,
    output logic             run_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             timeout
);

    // Elaboration-time parameter sanity checks.
    if (PIPE_DEPTH < 0 || PIPE_DEPTH > 15) begin : g_bad_pipe_depth
        $error("run_ctrl: PIPE_DEPTH must be in 0..15");
    end
    if (CNT_W < 1 || CNT_W > 63) begin : g_bad_cnt_w
        $error("run_ctrl: CNT_W must be in 1..63");
    end
    if (WDOG_LIMIT < 1) begin : g_bad_wdog_limit
        $error("run_ctrl: WDOG_LIMIT must be positive");
    end

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(PIPE_DEPTH);

    state_t           state_q;
    state_t           state_d;
    logic             req_q;
    logic             start;
    logic [3:0]       drain_q;
    logic [CNT_W-1:0] cycle_cnt_q;
    logic             wdog_hit;

    // NOTE: req_q has no reset on purpose. The parent ties reset and req
    // together, so the falling edge of req coincides with reset dropping;
    // clearing req_q under reset would lose that edge and the run would
    // never start.
    always_ff @(posedge clk) begin
        req_q <= req;
    end

    assign start = req_q && !req && !reset;

`ifdef RUN_CTRL_WATCHDOG_EN
    localparam longint unsigned CNT_MAX   = (64'd1 << CNT_W) - 64'd1;
    // A limit the counter can never reach must not alias onto a small value.
    localparam bit              WDOG_FITS = (64'(WDOG_LIMIT) <= CNT_MAX);
    localparam logic [CNT_W-1:0] WDOG_CNT = CNT_W'(WDOG_LIMIT);

    logic timeout_q;

    // A halt on the limit cycle wins over the abort.
    assign wdog_hit = WDOG_FITS && (state_q == RUN) &&
                      (cycle_cnt_q == WDOG_CNT) && !halt_i;
    assign timeout  = timeout_q;
`else
    assign wdog_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

    // -----------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = INIT;
            end
            INIT: begin
                state_d = RUN;
            end
            RUN: begin
                if (halt_i) begin
                    state_d = (PIPE_DEPTH == 0) ? DONE : DRAIN;
                end else if (wdog_hit) begin
                    state_d = DONE;
                end
            end
            DRAIN: begin
                if (drain_q == 4'd1) state_d = DONE;
            end
            DONE: begin
                if (start) state_d = INIT;
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------
    // Outputs: pure decodes of the registered state
    // -----------------------------------------------------------------
    always_comb begin
        pc_rst = 1'b0;
        run_en = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (state_q)
            IDLE:  ;
            INIT:  begin pc_rst = 1'b1; busy = 1'b1; end
            RUN:   begin run_en = 1'b1; busy = 1'b1; end
            DRAIN: busy = 1'b1;
            DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign cycle_cnt = cycle_cnt_q;

    // -----------------------------------------------------------------
    // Run-cycle counter, drain counter and watchdog flag
    // -----------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            drain_q     <= '0;
`ifdef RUN_CTRL_WATCHDOG_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    // Clear on the start edge so INIT and the first RUN
                    // cycle already read zero.
                    if (start) begin
                        cycle_cnt_q <= '0;
`ifdef RUN_CTRL_WATCHDOG_EN
                        timeout_q   <= 1'b0;
`endif
                    end
                end
                INIT: begin
                    cycle_cnt_q <= '0;
                end
                RUN: begin
                    // The aborting cycle is not counted, so a watchdog
                    // stop reports exactly WDOG_LIMIT.
                    if (!wdog_hit && cycle_cnt_q != '1) begin
                        cycle_cnt_q <= cycle_cnt_q + 1'b1;
                    end
                    if (halt_i) begin
                        drain_q <= DRAIN_LOAD;
                    end
`ifdef RUN_CTRL_WATCHDOG_EN
                    if (wdog_hit) begin
                        timeout_q <= 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    drain_q <= drain_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_run_ctrl
//   Directed scoreboard bench for run_ctrl. Three instances share the same
//   inputs:
//     dut  : PIPE_DEPTH=1, WDOG_LIMIT=8
//     dut0 : PIPE_DEPTH=0
//     dut2 : PIPE_DEPTH=2, CNT_W=3 (saturation and multi-cycle drain)
//   Each stimulus step pushes the hand-computed outputs expected after the
//   next clock edge; a monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_run_ctrl;

    logic        clk;
    logic        reset;
    logic        req;
    logic        halt_i;

    logic        pc_rst, run_en, busy, done, timeout;
    logic [15:0] cycle_cnt;
    logic        pc_rst0, run_en0, busy0, done0, timeout0;
    logic [15:0] cycle_cnt0;
    logic        pc_rst2, run_en2, busy2, done2, timeout2;
    logic [2:0]  cycle_cnt2;

    run_ctrl #(.PIPE_DEPTH(1), .CNT_W(16), .WDOG_LIMIT(8)) dut (
        .clk(clk), .reset(reset), .req(req), .halt_i(halt_i),
        .pc_rst(pc_rst), .run_en(run_en), .busy(busy), .done(done),
        .cycle_cnt(cycle_cnt), .timeout(timeout)
    );

    run_ctrl #(.PIPE_DEPTH(0), .CNT_W(16), .WDOG_LIMIT(8)) dut0 (
        .clk(clk), .reset(reset), .req(req), .halt_i(halt_i),
        .pc_rst(pc_rst0), .run_en(run_en0), .busy(busy0), .done(done0),
        .cycle_cnt(cycle_cnt0), .timeout(timeout0)
    );

    run_ctrl #(.PIPE_DEPTH(2), .CNT_W(3)) dut2 (
        .clk(clk), .reset(reset), .req(req), .halt_i(halt_i),
        .pc_rst(pc_rst2), .run_en(run_en2), .busy(busy2), .done(done2),
        .cycle_cnt(cycle_cnt2), .timeout(timeout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag order: {pc_rst, run_en, busy, done, timeout}
    localparam logic [4:0] F_IDLE  = 5'b00000;
    localparam logic [4:0] F_INIT  = 5'b10100;
    localparam logic [4:0] F_RUN   = 5'b01100;
    localparam logic [4:0] F_DRAIN = 5'b00100;
    localparam logic [4:0] F_DONE  = 5'b00010;
    localparam logic [4:0] F_DONET = 5'b00011;

    typedef struct {
        int          inst;
        logic [4:0]  flags;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [20:0] act,
                         input logic [20:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got flags=%b cnt=%0d, want flags=%b cnt=%0d",
                     name, act[20:16], act[15:0], exp[20:16], exp[15:0]);
        end
    endtask

    // Monitor: one expected entry per checked cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [20:0] act;
            e = exp_q.pop_front();
            case (e.inst)
                0:       act = {pc_rst, run_en, busy, done, timeout, cycle_cnt};
                1:       act = {pc_rst0, run_en0, busy0, done0, timeout0, cycle_cnt0};
                default: act = {pc_rst2, run_en2, busy2, done2, timeout2, 13'd0, cycle_cnt2};
            endcase
            check(e.name, act, {e.flags, e.cnt});
        end
    end

    // Apply inputs, take one edge, then queue the outputs expected after it.
    task automatic step(input logic rst, input logic rq, input logic h,
                        input int inst, input logic [4:0] fl,
                        input logic [15:0] cn, input string nm);
        exp_t e;
        reset  = rst;
        req    = rq;
        halt_i = h;
        @(posedge clk);
        #1;
        e.inst  = inst;
        e.flags = fl;
        e.cnt   = cn;
        e.name  = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout: got no finish, want finish before 50000");
        $fatal(1, "bench timed out");
    end

    initial begin
        reset  = 1'b1;
        req    = 1'b1;
        halt_i = 1'b0;

        // 1: reset and req tied high for one cycle, then both drop.
        step(1, 1, 0, 0, F_IDLE,  0, "s1_reset");
        step(0, 0, 0, 0, F_INIT,  0, "s1_init");
        step(0, 0, 0, 0, F_RUN,   0, "s1_run1");
        step(0, 0, 0, 0, F_RUN,   1, "s1_run2");
        step(0, 0, 0, 0, F_RUN,   2, "s1_run3");
        step(0, 0, 1, 0, F_DRAIN, 3, "s1_drain");
        step(0, 0, 0, 0, F_DONE,  3, "s1_done");
        step(0, 0, 0, 0, F_DONE,  3, "s1_done_hold");

        // 2: two-cycle req pulse from DONE, halt on RUN cycle 5.
        step(0, 1, 0, 0, F_DONE,  3, "s2_req_hi1");
        step(0, 1, 0, 0, F_DONE,  3, "s2_req_hi2");
        step(0, 0, 0, 0, F_INIT,  0, "s2_init");
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, F_RUN, 16'(i), "s2_run");
        end
        step(0, 0, 1, 0, F_DRAIN, 5, "s2_drain");
        step(0, 0, 0, 0, F_DONE,  5, "s2_done");

        // 3: reset alone mid-run, then stay idle.
        step(0, 1, 0, 0, F_DONE,  5, "s3_req_hi");
        step(0, 0, 0, 0, F_INIT,  0, "s3_init");
        step(0, 0, 0, 0, F_RUN,   0, "s3_run1");
        step(0, 0, 0, 0, F_RUN,   1, "s3_run2");
        step(1, 0, 0, 0, F_IDLE,  0, "s3_reset1");
        step(1, 0, 0, 0, F_IDLE,  0, "s3_reset2");
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, F_IDLE, 0, "s3_stay_idle");
        end

        // 4: halt held through IDLE and INIT; req toggled during RUN.
        step(0, 1, 1, 0, F_IDLE,  0, "s4_idle_halt");
        step(0, 0, 1, 0, F_INIT,  0, "s4_init");
        step(0, 0, 1, 0, F_RUN,   0, "s4_run_after_init_halt");
        step(0, 1, 0, 0, F_RUN,   1, "s4_req_toggle1");
        step(0, 0, 0, 0, F_RUN,   2, "s4_req_toggle2");
        step(0, 1, 0, 0, F_RUN,   3, "s4_req_toggle3");
        step(0, 0, 0, 0, F_RUN,   4, "s4_req_toggle4");
        step(0, 0, 1, 0, F_DRAIN, 5, "s4_drain");
        step(0, 0, 0, 0, F_DONE,  5, "s4_done");
        step(0, 0, 0, 0, F_DONE,  5, "s4_done_hold");

        // 5: PIPE_DEPTH=0, halt on RUN cycle 1.
        step(1, 0, 0, 1, F_IDLE,  0, "s5_reset");
        step(0, 1, 0, 1, F_IDLE,  0, "s5_req_hi");
        step(0, 0, 0, 1, F_INIT,  0, "s5_init");
        step(0, 0, 0, 1, F_RUN,   0, "s5_run1");
        step(0, 0, 1, 1, F_DONE,  1, "s5_done");
        step(0, 0, 0, 1, F_DONE,  1, "s5_done_hold");

        // Counter saturation (CNT_W=3) and two-cycle drain.
        step(1, 0, 0, 2, F_IDLE,  0, "sat_reset");
        step(0, 1, 0, 2, F_IDLE,  0, "sat_req_hi");
        step(0, 0, 0, 2, F_INIT,  0, "sat_init");
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 2, F_RUN, 16'(i), "sat_count");
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 2, F_RUN, 7, "sat_hold");
        end
        step(0, 0, 1, 2, F_DRAIN, 7, "sat_drain1");
        step(0, 0, 0, 2, F_DRAIN, 7, "sat_drain2");
        step(0, 0, 0, 2, F_DONE,  7, "sat_done");

        // 6: watchdog limit 8, halt held low.
        step(1, 0, 0, 0, F_IDLE,  0, "s6_reset");
        step(0, 1, 0, 0, F_IDLE,  0, "s6_req_hi");
        step(0, 0, 0, 0, F_INIT,  0, "s6_init");
        step(0, 0, 0, 0, F_RUN,   0, "s6_run1");
        for (int i = 1; i <= 20; i++) begin
`ifdef RUN_CTRL_WATCHDOG_EN
            if (i <= 8) step(0, 0, 0, 0, F_RUN,   16'(i), "s6_run");
            else        step(0, 0, 0, 0, F_DONET, 8,      "s6_wdog_done");
`else
            step(0, 0, 0, 0, F_RUN, 16'(i), "s6_run_no_wdog");
`endif
        end
`ifdef RUN_CTRL_WATCHDOG_EN
        // A new start clears timeout in INIT.
        step(0, 1, 0, 0, F_DONET, 8, "s6_req_hi");
        step(0, 0, 0, 0, F_INIT,  0, "s6_restart_init");
        step(0, 0, 0, 0, F_RUN,   0, "s6_restart_run");
`endif

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
